wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the pipeline writeback stage (the output of the memory-to-writeback register) and a long-latency unit (LU: mul/div) that returns results out of band.
- Keeps a destination scoreboard for outstanding LU ops and raises a decode hazard when a source or destination register is busy.
- Uses a starvation counter and FSM that freezes the pipeline for one cycle when the LU result has waited too long.

---
 rtl/wb_port_arbiter_if.sv | 41 ++++
 rtl/wb_port_arbiter.sv | 119 +++++++++++
 tb/tb_wb_port_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port arbitration bundle: pipeline W-stage write, LU result
// handshake, decode hazard query and the resulting write port / stall / bypass.
interface wb_port_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      reg_writeW_i;
  logic [REG_ADDR_WIDTH-1:0] rdW_i;
  logic [DATA_WIDTH-1:0]     resultW_i;
  logic                      lu_issue_i;
  logic [REG_ADDR_WIDTH-1:0] lu_rdD_i;
  logic                      lu_valid_i;
  logic [REG_ADDR_WIDTH-1:0] lu_rd_i;
  logic [DATA_WIDTH-1:0]     lu_result_i;
  logic                      lu_ready_o;
  logic [REG_ADDR_WIDTH-1:0] rs1D_i;
  logic [REG_ADDR_WIDTH-1:0] rs2D_i;
  logic                      reg_writeD_i;
  logic [REG_ADDR_WIDTH-1:0] rdD_i;
  logic                      reg_write_o;
  logic [REG_ADDR_WIDTH-1:0] rd_o;
  logic [DATA_WIDTH-1:0]     wd_o;
  logic                      stall_o;
  logic                      busy_stall_o;
  logic                      fwd_valid_o;
  logic [DATA_WIDTH-1:0]     fwd_data_o;

  modport slave (
    input  reg_writeW_i, rdW_i, resultW_i, lu_issue_i, lu_rdD_i,
           lu_valid_i, lu_rd_i, lu_result_i, rs1D_i, rs2D_i, reg_writeD_i, rdD_i,
    output lu_ready_o, reg_write_o, rd_o, wd_o, stall_o, busy_stall_o,
           fwd_valid_o, fwd_data_o
  );

  modport master (
    output reg_writeW_i, rdW_i, resultW_i, lu_issue_i, lu_rdD_i,
           lu_valid_i, lu_rd_i, lu_result_i, rs1D_i, rs2D_i, reg_writeD_i, rdD_i,
    input  lu_ready_o, reg_write_o, rd_o, wd_o, stall_o, busy_stall_o,
           fwd_valid_o, fwd_data_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the W stage and the long-latency unit,
// with a busy scoreboard and starvation-forced grant. Define ARB_BYPASS_EN for LU bypass.
module wb_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_port_arbiter_if.slave  bus
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREG-1:0] busy_q, busy_d, busy_v;
  logic            pipe_wr, lu_grant, lu_xfer;

  assign pipe_wr = bus.reg_writeW_i && (bus.rdW_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.lu_valid_i && pipe_wr) begin
          state_d = ST_WAIT;
          cnt_d   = 4'd1;
        end
      end
      ST_WAIT: begin
        if (!pipe_wr) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < LIMIT) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FORCE always hands the port to the LU; the held W write retires next cycle
  always_comb begin
    lu_grant = 1'b0;
    if (bus.lu_valid_i && !rst_i) begin
      case (state_q)
        ST_IDLE, ST_WAIT: lu_grant = !pipe_wr;
        ST_FORCE:         lu_grant = 1'b1;
        default:          lu_grant = 1'b0;
      endcase
    end
    bus.lu_ready_o  = lu_grant;
    bus.stall_o     = (state_q == ST_FORCE) && !rst_i;
    bus.reg_write_o = 1'b0;
    bus.rd_o        = bus.rdW_i;
    bus.wd_o        = bus.resultW_i;
    if (lu_grant) begin
      bus.reg_write_o = (bus.lu_rd_i != '0);
      bus.rd_o        = bus.lu_rd_i;
      bus.wd_o        = bus.lu_result_i;
    end else if (state_q != ST_FORCE && !rst_i) begin
      bus.reg_write_o = bus.reg_writeW_i;
    end
  end

  assign lu_xfer = bus.lu_valid_i && lu_grant;

  // Hazard view of the scoreboard; with bypass the granted register is already available
  always_comb begin
    busy_v = busy_q;
`ifdef ARB_BYPASS_EN
    if (lu_grant) busy_v[bus.lu_rd_i] = 1'b0;
    bus.fwd_valid_o = lu_grant;
    bus.fwd_data_o  = lu_grant ? bus.lu_result_i : '0;
`else
    bus.fwd_valid_o = 1'b0;
    bus.fwd_data_o  = '0;
`endif
    bus.busy_stall_o = busy_v[bus.rs1D_i] | busy_v[bus.rs2D_i]
                     | (bus.reg_writeD_i & busy_v[bus.rdD_i])
                     | (bus.lu_issue_i & busy_v[bus.lu_rdD_i]);
  end

  // Clear before set so a same-index issue in the transfer cycle wins
  always_comb begin
    busy_d = busy_q;
    if (lu_xfer) busy_d[bus.lu_rd_i] = 1'b0;
    if (bus.lu_issue_i && !bus.busy_stall_o) busy_d[bus.lu_rdD_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter; expectations follow ARB_BYPASS_EN.
module tb_wb_port_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;
`ifdef ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  wb_port_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string          tag;
    logic           rw;
    logic [AW-1:0]  rd;
    logic [DW-1:0]  wd;
    logic           cd;
    logic           rdy;
    logic           stall;
    logic           bs;
    logic           fv;
    logic [DW-1:0]  fd;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic push(input string tag, input logic rw, input logic [AW-1:0] rd,
                      input logic [DW-1:0] wd, input logic cd, input logic rdy,
                      input logic stall, input logic bs);
    exp_t e;
    e.tag = tag; e.rw = rw; e.rd = rd; e.wd = wd; e.cd = cd;
    e.rdy = rdy; e.stall = stall; e.bs = bs;
    e.fv  = BYP ? rdy : 1'b0;
    e.fd  = (BYP && rdy) ? wd : '0;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input string what, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, act, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_empty observed=0 entries expected=1");
    end else begin
      e = q.pop_front();
      chk(e.tag, "reg_write", DW'(bus.reg_write_o), DW'(e.rw));
      chk(e.tag, "lu_ready", DW'(bus.lu_ready_o), DW'(e.rdy));
      chk(e.tag, "stall", DW'(bus.stall_o), DW'(e.stall));
      chk(e.tag, "busy_stall", DW'(bus.busy_stall_o), DW'(e.bs));
      chk(e.tag, "fwd_valid", DW'(bus.fwd_valid_o), DW'(e.fv));
      chk(e.tag, "fwd_data", bus.fwd_data_o, e.fd);
      if (e.cd) begin
        chk(e.tag, "rd", DW'(bus.rd_o), DW'(e.rd));
        chk(e.tag, "wd", bus.wd_o, e.wd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic zero();
    bus.reg_writeW_i = 1'b0; bus.rdW_i = '0; bus.resultW_i = '0;
    bus.lu_issue_i = 1'b0; bus.lu_rdD_i = '0;
    bus.lu_valid_i = 1'b0; bus.lu_rd_i = '0; bus.lu_result_i = '0;
    bus.rs1D_i = '0; bus.rs2D_i = '0; bus.reg_writeD_i = 1'b0; bus.rdD_i = '0;
  endtask

  // LU result waits behind LIM+1 pipeline writes, is forced in, then the held W write retires
  task automatic starve(input string tag, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                        input logic [AW-1:0] wrd, input logic [DW-1:0] wdat);
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = lrd; bus.lu_result_i = ld;
    bus.reg_writeW_i = 1'b1; bus.rdW_i = wrd; bus.resultW_i = wdat;
    for (int i = 0; i <= LIM; i++) begin
      push({tag, "_pipe"}, 1'b1, wrd, wdat, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    push({tag, "_force"}, 1'b1, lrd, ld, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    bus.lu_valid_i = 1'b0;
    push({tag, "_retire"}, 1'b1, wrd, wdat, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    zero();
    rst = 1'b1;
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd5;
    bus.reg_writeW_i = 1'b1; bus.rdW_i = 5'd3;
    push("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    zero();

    bus.lu_issue_i = 1'b1; bus.lu_rdD_i = 5'd5;
    push("issue5", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    zero(); bus.rs1D_i = 5'd5;
    push("busy5", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd5; bus.lu_result_i = 32'hDEADBEEF;
    push("grant5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, !BYP);
    cyc();
    bus.lu_valid_i = 1'b0;
    push("clear5", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    zero();

    starve("starve7", 5'd7, 32'h0000_0077, 5'd3, 32'h0000_0033);
    zero();

    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd9; bus.lu_result_i = 32'h0000_0099;
    bus.reg_writeW_i = 1'b1; bus.rdW_i = 5'd8; bus.resultW_i = 32'h0000_0088;
    for (int i = 0; i < 2; i++) begin
      push("wait9_pipe", 1'b1, 5'd8, 32'h0000_0088, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    bus.reg_writeW_i = 1'b0;
    push("wait9_bubble", 1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    zero();
    push("wait9_idle", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();

    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd11; bus.lu_result_i = 32'h0000_000B;
    bus.reg_writeW_i = 1'b1; bus.rdW_i = '0; bus.resultW_i = 32'h0000_1111;
    push("w_rd0_grant", 1'b1, 5'd11, 32'h0000_000B, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    zero();
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = '0; bus.lu_result_i = 32'h0000_1234;
    push("lu_rd0", 1'b0, '0, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    zero();

    bus.lu_issue_i = 1'b1; bus.lu_rdD_i = 5'd10;
    push("issue10", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    zero(); bus.rs1D_i = 5'd10;
    for (int i = 0; i < 2; i++) begin
      push("busy10", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd10; bus.lu_result_i = 32'h0000_A0A0;
    push("grant10", 1'b1, 5'd10, 32'h0000_A0A0, 1'b1, 1'b1, 1'b0, !BYP);
    cyc();
    bus.lu_valid_i = 1'b0;
    push("after10", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    zero();

    bus.lu_issue_i = 1'b1; bus.lu_rdD_i = 5'd4;
    push("issue4", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd4; bus.lu_result_i = 32'h0000_0044;
    push("xfer_issue4", 1'b1, 5'd4, 32'h0000_0044, 1'b1, 1'b1, 1'b0, !BYP);
    cyc();
    zero(); bus.rs1D_i = 5'd4;
    push("busy4_after", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, BYP);
    cyc();
    zero(); bus.lu_issue_i = 1'b1; bus.lu_rdD_i = 5'd4;
    push("reissue4", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, BYP);
    cyc();
    zero(); bus.rs2D_i = 5'd4;
    push("busy4_set", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();
    zero();

    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd12; bus.lu_result_i = 32'h0000_00CC;
    bus.reg_writeW_i = 1'b1; bus.rdW_i = 5'd2; bus.resultW_i = 32'h0000_0022;
    push("enter_wait", 1'b1, 5'd2, 32'h0000_0022, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b1;
    push("reset_in_wait", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    bus.lu_valid_i = 1'b0; bus.rs1D_i = 5'd4;
    push("post_reset", 1'b1, 5'd2, 32'h0000_0022, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    zero();
    starve("starve13", 5'd13, 32'h0000_00DD, 5'd2, 32'h0000_0022);

    if (q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
